// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline-stage state encoding and control-bit positions.
package pipe_pkg;
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} pipe_state_t;
    localparam int CTRL_RW   = 0;
    localparam int CTRL_MW   = 1;
    localparam int CTRL_MR   = 2;
    localparam int CTRL_BR   = 3;
    localparam int CTRL_IW   = 4;
    localparam int CTRL_PUSH = 5;
    localparam int CTRL_POP  = 6;
endpackage

// File: rtl/pipe_entry_reg.sv
// pipe_entry_reg: one valid/ctrl/data slot; ctrl is zeroed whenever the slot goes invalid.
module pipe_entry_reg #(
    parameter int CTRL_W = 16,
    parameter int DATA_W = 96
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_clear,
    input  logic              i_load,
    input  logic              i_valid,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [DATA_W-1:0] o_data
);
    logic              r_valid;
    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_data;

    // Payload only moves with a valid word so it holds its last value otherwise.
    always_ff @(posedge clk)
        if (reset) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            r_data  <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end else if (i_load) begin
            r_valid <= i_valid;
            r_ctrl  <= i_valid ? i_ctrl : '0;
            if (i_valid) r_data <= i_data;
        end

    assign o_valid = r_valid;
    assign o_ctrl  = r_ctrl;
    assign o_data  = r_data;
endmodule

// File: rtl/pipe_stage_buffer.sv
// pipe_stage_buffer: ready/valid pipeline register with optional skid entry and flush.
module pipe_stage_buffer
    import pipe_pkg::*;
#(
    parameter int DATA_W  = 96,
    parameter int CTRL_W  = 16,
    parameter bit SKID_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);
    pipe_state_t       r_state, w_state_nxt;
    logic              r_in_ready;
    logic              w_accept, w_xfer, w_m_load, w_s_load, w_m_in_valid;
    logic              w_s_valid;
    logic [CTRL_W-1:0] w_s_ctrl, w_m_in_ctrl;
    logic [DATA_W-1:0] w_s_data, w_m_in_data;

    assign in_ready  = SKID_EN ? r_in_ready : (!out_valid || out_ready);
    assign w_accept  = in_valid && in_ready;
    assign w_xfer    = out_valid && out_ready;
    assign occupancy = r_state;

    // Main refills whenever it drains or is empty; from skid when FULL, else from input.
    assign w_m_load     = w_xfer || !out_valid;
    assign w_m_in_valid = (r_state == FULL) ? w_s_valid : w_accept;
    assign w_m_in_ctrl  = (r_state == FULL) ? w_s_ctrl  : in_ctrl;
    assign w_m_in_data  = (r_state == FULL) ? w_s_data  : in_data;
    assign w_s_load     = SKID_EN && (((r_state == ONE) && w_accept && !w_xfer) ||
                                      ((r_state == FULL) && w_xfer));

    always_comb begin
        w_state_nxt = r_state;
        if (flush)
            w_state_nxt = EMPTY;
        else if (r_state == EMPTY)
            w_state_nxt = w_accept ? ONE : EMPTY;
        else if (r_state == ONE)
            w_state_nxt = (w_accept && !w_xfer) ? FULL : (!w_accept && w_xfer) ? EMPTY : ONE;
        else
            w_state_nxt = w_xfer ? ONE : FULL;
    end

    always_ff @(posedge clk)
        if (reset) begin
            r_state    <= EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != FULL);
        end

    pipe_entry_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
        .clk(clk), .reset(reset), .i_clear(flush), .i_load(w_m_load),
        .i_valid(w_m_in_valid), .i_ctrl(w_m_in_ctrl), .i_data(w_m_in_data),
        .o_valid(out_valid), .o_ctrl(out_ctrl), .o_data(out_data)
    );

    pipe_entry_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
        .clk(clk), .reset(reset), .i_clear(flush), .i_load(w_s_load),
        .i_valid(w_accept), .i_ctrl(in_ctrl), .i_data(in_data),
        .o_valid(w_s_valid), .o_ctrl(w_s_ctrl), .o_data(w_s_data)
    );
endmodule

// File: tb/tb_pipe_stage_buffer.sv
// tb_pipe_stage_buffer: directed checks of the skid (SKID_EN=1) and single-entry (SKID_EN=0) buffers.
module tb_pipe_stage_buffer;
    logic        clk = 1'b0;
    logic        reset, flush;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] in_ctrl, out_ctrl;
    logic [95:0] in_data, out_data;
    logic [1:0]  occupancy;
    logic        z_in_valid, z_in_ready, z_out_valid, z_out_ready;
    logic [15:0] z_in_ctrl, z_out_ctrl;
    logic [95:0] z_in_data, z_out_data;
    logic [1:0]  z_occupancy;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    pipe_stage_buffer #(.DATA_W(96), .CTRL_W(16), .SKID_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .occupancy(occupancy)
    );

    pipe_stage_buffer #(.DATA_W(96), .CTRL_W(16), .SKID_EN(1'b0)) dut0 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(z_in_valid), .in_ready(z_in_ready), .in_ctrl(z_in_ctrl), .in_data(z_in_data),
        .out_valid(z_out_valid), .out_ready(z_out_ready), .out_ctrl(z_out_ctrl), .out_data(z_out_data),
        .occupancy(z_occupancy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0;
        in_valid = 1'b0; in_ctrl = '0; in_data = '0; out_ready = 1'b1;
        z_in_valid = 1'b0; z_in_ctrl = '0; z_in_data = '0; z_out_ready = 1'b1;
        step(); step();
        reset = 1'b0;
        chk("rst_valid", out_valid, 0);
        chk("rst_ctrl", out_ctrl, 0);
        chk("rst_data", out_data, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_occ", occupancy, 0);

        in_valid = 1'b1; in_ctrl = 16'h00A5; in_data = 96'h1234;
        step();
        in_valid = 1'b0;
        chk("t1_valid", out_valid, 1);
        chk("t1_ctrl", out_ctrl, 16'h00A5);
        chk("t1_data", out_data, 96'h1234);
        chk("t1_occ", occupancy, 1);
        step();
        chk("t1_drain_valid", out_valid, 0);
        chk("t1_drain_ctrl", out_ctrl, 0);
        chk("t1_hold_data", out_data, 96'h1234);

        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_ctrl = 16'(i); in_data = 96'(i);
            step();
            chk("t2_ready", in_ready, 1);
            chk("t2_valid", out_valid, 1);
            chk("t2_data", out_data, 128'(i));
        end
        in_valid = 1'b0;
        step();
        chk("t2_end_valid", out_valid, 0);
        chk("t2_end_occ", occupancy, 0);

        out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 16'h0011; in_data = 96'hA;
        step();
        chk("t3_a_data", out_data, 96'hA);
        chk("t3_a_ready", in_ready, 1);
        chk("t3_a_occ", occupancy, 1);
        in_ctrl = 16'h0022; in_data = 96'hB;
        step();
        in_valid = 1'b0;
        chk("t3_full_occ", occupancy, 2);
        chk("t3_full_ready", in_ready, 0);
        chk("t3_full_data", out_data, 96'hA);
        step();
        chk("t3_stall_data", out_data, 96'hA);
        chk("t3_stall_ctrl", out_ctrl, 16'h0011);
        chk("t3_stall_ready", in_ready, 0);
        out_ready = 1'b1;
        step();
        chk("t3_b_data", out_data, 96'hB);
        chk("t3_b_ctrl", out_ctrl, 16'h0022);
        chk("t3_b_ready", in_ready, 1);
        chk("t3_b_occ", occupancy, 1);
        step();
        chk("t3_end_valid", out_valid, 0);
        chk("t3_end_occ", occupancy, 0);

        out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 16'h0033; in_data = 96'hC0;
        step();
        in_ctrl = 16'h0044; in_data = 96'hD0;
        step();
        chk("t4_full_occ", occupancy, 2);
        flush = 1'b1; in_ctrl = 16'h0055; in_data = 96'hEE;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("t4_valid", out_valid, 0);
        chk("t4_ctrl", out_ctrl, 0);
        chk("t4_occ", occupancy, 0);
        chk("t4_ready", in_ready, 1);
        chk("t4_data_kept", out_data, 96'hC0);
        out_ready = 1'b1;
        step();
        chk("t4_no_c", out_valid, 0);
        flush = 1'b1; in_valid = 1'b1; in_ctrl = 16'h0077; in_data = 96'hF0;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("t4_empty_flush_valid", out_valid, 0);
        chk("t4_empty_flush_occ", occupancy, 0);

        out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 16'h0066; in_data = 96'h77;
        step();
        chk("t5_one_valid", out_valid, 1);
        reset = 1'b1; flush = 1'b1; in_valid = 1'b0;
        step();
        reset = 1'b0; flush = 1'b0;
        chk("t5_data", out_data, 0);
        chk("t5_valid", out_valid, 0);
        chk("t5_ctrl", out_ctrl, 0);
        chk("t5_ready", in_ready, 1);
        chk("t5_occ", occupancy, 0);

        z_out_ready = 1'b0; z_in_valid = 1'b1; z_in_ctrl = 16'h0081; z_in_data = 96'h1A;
        step();
        chk("t6_a_valid", z_out_valid, 1);
        chk("t6_a_data", z_out_data, 96'h1A);
        chk("t6_stall_ready", z_in_ready, 0);
        z_in_ctrl = 16'h0082; z_in_data = 96'h1B;
        step();
        chk("t6_no_full", z_occupancy, 1);
        chk("t6_hold_data", z_out_data, 96'h1A);
        chk("t6_hold_ready", z_in_ready, 0);
        z_out_ready = 1'b1;
        #1;
        chk("t6_comb_ready", z_in_ready, 1);
        step();
        z_in_valid = 1'b0;
        chk("t6_b_data", z_out_data, 96'h1B);
        chk("t6_b_ctrl", z_out_ctrl, 16'h0082);
        chk("t6_b_occ", z_occupancy, 1);
        step();
        chk("t6_end_valid", z_out_valid, 0);
        z_out_ready = 1'b0;
        #1;
        chk("t6_empty_ready", z_in_ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
